// File: rtl/cardinal_noc_pkg.sv
// cardinal_noc_pkg: shared packet field positions, port indices, request encodings and VC state type
package cardinal_noc_pkg;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_HOP_W  = 4;
   localparam int VC_BIT     = 63;
   localparam int XDIR_BIT   = 62;
   localparam int YDIR_BIT   = 61;
   localparam int XHOP_MSB   = 55;
   localparam int XHOP_LSB   = 52;
   localparam int YHOP_MSB   = 51;
   localparam int YHOP_LSB   = 48;
   localparam int PORT_N  = 0;
   localparam int PORT_S  = 1;
   localparam int PORT_E  = 2;
   localparam int PORT_W  = 3;
   localparam int PORT_PE = 4;
   localparam logic [4:0] REQ_N  = 5'b1 << PORT_N;
   localparam logic [4:0] REQ_S  = 5'b1 << PORT_S;
   localparam logic [4:0] REQ_E  = 5'b1 << PORT_E;
   localparam logic [4:0] REQ_W  = 5'b1 << PORT_W;
   localparam logic [4:0] REQ_PE = 5'b1 << PORT_PE;
   typedef enum logic {VC_EMPTY = 1'b0, VC_FULL = 1'b1} vc_state_t;
endpackage

// File: rtl/cardinal_route_calc.sv
// cardinal_route_calc: combinational XY route decision with hop decrement
//   pkt     in   packet to route
//   req     out  one-hot output request {PE,W,E,S,N}
//   pkt_out out  packet with the travelled hop field decremented
module cardinal_route_calc
   import cardinal_noc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int HOP_W  = DEF_HOP_W
) (
   input  logic [DATA_W-1:0] pkt,
   output logic [4:0]        req,
   output logic [DATA_W-1:0] pkt_out
);
   logic [HOP_W-1:0] xh, yh;
   assign xh = pkt[XHOP_LSB +: HOP_W];
   assign yh = pkt[YHOP_LSB +: HOP_W];
   // X is resolved fully before Y; fields are only decremented when non-zero
   always_comb begin
      pkt_out = pkt;
      req     = REQ_PE;
      if (xh != '0) begin
         pkt_out[XHOP_LSB +: HOP_W] = xh - 1'b1;
         req = pkt[XDIR_BIT] ? REQ_W : REQ_E;
      end else if (yh != '0) begin
         pkt_out[YHOP_LSB +: HOP_W] = yh - 1'b1;
         req = pkt[YDIR_BIT] ? REQ_S : REQ_N;
      end
   end
endmodule

// File: rtl/cardinal_router_inport.sv
// cardinal_router_inport: one router input port with a one-packet buffer per VC
//   clk, reset        clock, synchronous active-high reset
//   polarity          VC being forwarded; the other VC accepts writes
//   up_si/up_ri/up_di upstream send strobe, ready, packet
//   req/gnt/fwd_do    one-hot output request, grant, hop-updated packet
//   vc_full           buffer occupancy {odd,even}
//   stat_acc/stat_fwd accept/forward counters, present with CARDINAL_INPORT_STATS_EN
module cardinal_router_inport
   import cardinal_noc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int HOP_W  = DEF_HOP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              polarity,
   input  logic              up_si,
   output logic              up_ri,
   input  logic [DATA_W-1:0] up_di,
   output logic [4:0]        req,
   input  logic              gnt,
   output logic [DATA_W-1:0] fwd_do,
`ifdef CARDINAL_INPORT_STATS_EN
   output logic [1:0]        vc_full,
   output logic [31:0]       stat_acc,
   output logic [31:0]       stat_fwd
`else
   output logic [1:0]        vc_full
`endif
);
   vc_state_t [1:0]          st_q, st_d;
   logic [1:0][DATA_W-1:0]   buf_q;
   logic                     wr_vc, rd_vc, acc, fwd;
   logic [4:0]               route_req;
   logic [DATA_W-1:0]        route_pkt;
   // write and read sides always address opposite buffers, so accept and forward can coincide
   assign wr_vc   = ~polarity;
   assign rd_vc   = polarity;
   assign vc_full = {st_q[1] == VC_FULL, st_q[0] == VC_FULL};
   assign up_ri   = ~vc_full[wr_vc];
   assign acc     = up_si & up_ri;
   assign fwd     = vc_full[rd_vc] & gnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q  <= {VC_EMPTY, VC_EMPTY};
         buf_q <= '0;
      end else begin
         st_q <= st_d;
         if (acc) buf_q[wr_vc] <= up_di;
      end
   end
   always_comb begin
      st_d = st_q;
      if (acc) st_d[wr_vc] = VC_FULL;
      if (fwd) st_d[rd_vc] = VC_EMPTY;
   end
   cardinal_route_calc #(.DATA_W(DATA_W), .HOP_W(HOP_W)) u_route (
      .pkt     (buf_q[rd_vc]),
      .req     (route_req),
      .pkt_out (route_pkt)
   );
   assign req    = vc_full[rd_vc] ? route_req : 5'b0;
   assign fwd_do = vc_full[rd_vc] ? route_pkt : '0;
`ifdef CARDINAL_INPORT_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_acc <= '0;
         stat_fwd <= '0;
      end else begin
         stat_acc <= stat_acc + 32'(acc);
         stat_fwd <= stat_fwd + 32'(fwd);
      end
   end
`endif
endmodule

// File: tb/tb_cardinal_router_inport.sv
// tb_cardinal_router_inport: directed scoreboard bench for cardinal_router_inport
module tb_cardinal_router_inport;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        polarity = 1'b0;
   logic        up_si = 1'b0;
   logic        up_ri;
   logic [63:0] up_di = '0;
   logic [4:0]  req;
   logic        gnt = 1'b0;
   logic [63:0] fwd_do;
   logic [1:0]  vc_full;
`ifdef CARDINAL_INPORT_STATS_EN
   logic [31:0] stat_acc, stat_fwd;
`endif
   int checks = 0;
   int errors = 0;
   logic [68:0] sb[$];
   logic [68:0] e;

   always #5 clk = ~clk;

   cardinal_router_inport dut (
      .clk(clk), .reset(reset), .polarity(polarity), .up_si(up_si), .up_ri(up_ri),
      .up_di(up_di), .req(req), .gnt(gnt), .fwd_do(fwd_do),
`ifdef CARDINAL_INPORT_STATS_EN
      .vc_full(vc_full), .stat_acc(stat_acc), .stat_fwd(stat_fwd)
`else
      .vc_full(vc_full)
`endif
   );

   function automatic logic [63:0] mk(logic vc, logic xd, logic yd, logic [3:0] xh, logic [3:0] yh, logic [47:0] pl);
      return {vc, xd, yd, 5'b0, xh, yh, pl};
   endfunction

   // expected {req, fwd_do}: X first, then Y, else local delivery
   function automatic logic [68:0] model(logic [63:0] p);
      logic [63:0] q = p;
      logic [4:0] r;
      if (p[55:52] != 4'd0) begin
         q[55:52] = p[55:52] - 4'd1;
         r = p[62] ? 5'b01000 : 5'b00100;
      end else if (p[51:48] != 4'd0) begin
         q[51:48] = p[51:48] - 4'd1;
         r = p[61] ? 5'b00010 : 5'b00001;
      end else r = 5'b10000;
      return {r, q};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [63:0] p, bit accept);
      up_si = 1'b1;
      up_di = p;
      if (accept) sb.push_back(model(p));
      tick();
      up_si = 1'b0;
   endtask

   task automatic serve(string tag);
      #1;
      e = sb.pop_front();
      chk({tag, "_req"}, 64'(req), 64'(e[68:64]));
      chk({tag, "_data"}, fwd_do, e[63:0]);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk({tag, "_req_after"}, 64'(req), 64'd0);
   endtask

   initial begin
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_ri", 64'(up_ri), 64'd1);
      chk("rst_req", 64'(req), 64'd0);
      chk("rst_full", 64'(vc_full), 64'd0);
      chk("rst_fwd", fwd_do, 64'd0);
      // X east
      polarity = 1'b0;
      send(mk(1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 48'h1111_2222_3333), 1'b1);
      chk("xe_full", 64'(vc_full), 64'd2);
      polarity = 1'b1;
      serve("xe");
      chk("xe_empty", 64'(vc_full), 64'd0);
      // Y south
      polarity = 1'b0;
      send(mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 48'hABCD_0000_0042), 1'b1);
      polarity = 1'b1;
      serve("ys");
      // local delivery
      polarity = 1'b0;
      send(mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 48'hDEAD_BEEF_0001), 1'b1);
      polarity = 1'b1;
      serve("pe");
      // X west and Y north via the even buffer
      send(mk(1'b1, 1'b1, 1'b0, 4'd1, 4'd5, 48'h0000_0000_0007), 1'b1);
      chk("xw_full", 64'(vc_full), 64'd1);
      polarity = 1'b0;
      serve("xw");
      polarity = 1'b1;
      send(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 48'hFFFF_FFFF_FFFF), 1'b1);
      polarity = 1'b0;
      serve("yn");
      // backpressure: second packet dropped while odd buffer full
      send(mk(1'b0, 1'b0, 1'b1, 4'd4, 4'd0, 48'h5555_5555_5555), 1'b1);
      chk("bp_ri", 64'(up_ri), 64'd0);
      send(mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 48'h6666_6666_6666), 1'b0);
      chk("bp_full", 64'(vc_full), 64'd2);
      polarity = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", 64'(req), 64'(sb[0][68:64]));
      end
      polarity = 1'b0;
      #1;
      chk("bp_other_req", 64'(req), 64'd0);
      tick();
      polarity = 1'b1;
      serve("bp");
      chk("bp_drop", 64'(vc_full), 64'd0);
      // simultaneous forward and accept on opposite buffers
      send(mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd2, 48'h0123_4567_89AB), 1'b1);
      polarity = 1'b0;
      #1;
      e = sb.pop_front();
      chk("sim_req", 64'(req), 64'(e[68:64]));
      chk("sim_data", fwd_do, e[63:0]);
      gnt = 1'b1;
      send(mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 48'hCAFE_F00D_0000), 1'b1);
      gnt = 1'b0;
      chk("sim_full", 64'(vc_full), 64'd2);
      polarity = 1'b1;
      serve("sim_next");
      // reset with both buffers full
      polarity = 1'b0;
      send(mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 48'h1), 1'b1);
      polarity = 1'b1;
      send(mk(1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 48'h2), 1'b1);
      chk("both_full", 64'(vc_full), 64'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      chk("mid_rst_full", 64'(vc_full), 64'd0);
      chk("mid_rst_req", 64'(req), 64'd0);
      chk("mid_rst_ri", 64'(up_ri), 64'd1);
      // three accepts and two forwards after reset
      polarity = 1'b0;
      send(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 48'hA), 1'b1);
      polarity = 1'b1;
      send(mk(1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 48'hB), 1'b1);
      serve("st_a");
      polarity = 1'b0;
      serve("st_b");
      send(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hC), 1'b1);
`ifdef CARDINAL_INPORT_STATS_EN
      chk("stat_acc", 64'(stat_acc), 64'd3);
      chk("stat_fwd", 64'(stat_fwd), 64'd2);
`endif
      chk("end_full", 64'(vc_full), 64'd2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
